// File: rtl/softmax_unpacker.sv
// rtl/softmax_unpacker.sv - buffers 128-bit softmax vectors, serializes them to 16-bit words, reports argmax
module softmax_unpacker #(
  parameter int DEPTH = 2,
  parameter int WORDS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid,
  input  logic [127:0] data_in,
  input  logic         full,
  output logic         wr_en,
  output logic [15:0]  data_out,
  output logic         done,
  output logic         argmax_valid,
  output logic [3:0]   argmax_idx,
  output logic [7:0]   argmax_val,
  output logic         busy,
  output logic [7:0]   drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_nxt;
  logic [127:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] word_cnt;
  logic          push, pop;
  logic [127:0]  head;
  logic [3:0]    max_idx;
  logic [7:0]    max_val;

  // A slot freed by this cycle's pop is not reusable until next cycle, so push looks at the old count.
  assign push = valid && (count < FULL_CNT);
  assign head = mem[rd_ptr];
  assign busy = (count != '0) || (state == SEND);

  // Vector storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Circular-buffer pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (valid && !push && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and write-side outputs; a stall simply holds word_cnt so data_out stays put.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    data_out  = '0;
    pop       = 1'b0;
    case (state)
      IDLE: if (count != '0) state_nxt = SEND;
      SEND: begin
        wr_en    = !full;
        data_out = head[{word_cnt, 4'b0000} +: 16];
        if (!full && (word_cnt == LAST_WORD)) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word counter restarts at 0 whenever the FSM is idle and advances on each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              word_cnt <= '0;
    else if (state == IDLE)  word_cnt <= '0;
    else if (wr_en)          word_cnt <= pop ? '0 : word_cnt + 1'b1;
  end

  // Argmax over the 16 unsigned lanes of the head vector; strict compare keeps the lowest lane on ties.
  always_comb begin
    max_idx = '0;
    max_val = head[7:0];
    for (int i = 1; i < 16; i++) begin
      if (head[8*i +: 8] > max_val) begin
        max_val = head[8*i +: 8];
        max_idx = 4'(i);
      end
    end
  end

  // Completion pulses and argmax result, registered on the cycle the last word goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done         <= 1'b0;
      argmax_valid <= 1'b0;
      argmax_idx   <= '0;
      argmax_val   <= '0;
    end else begin
      done         <= pop;
      argmax_valid <= pop;
      if (pop) begin
        argmax_idx <= max_idx;
        argmax_val <= max_val;
      end
    end
  end

endmodule
